// File: rtl/tx3_block_assembler.sv
// Packs a valid/ready word stream into DATA_WIDTH-bit blocks for the tx3 cipher core.
// A short final block is padded with PAD_WORD and held until the consumer accepts it.
module tx3_block_assembler #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] PAD_WORD = 8'h80,
  localparam int unsigned WORDS = DATA_WIDTH / WORD_WIDTH,
  localparam int unsigned CW = $clog2(WORDS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic [CW-1:0]         block_pad_count_o
);

  generate
    if ((DATA_WIDTH % WORD_WIDTH) != 0) begin : g_width_check
      $error("DATA_WIDTH must be a multiple of WORD_WIDTH");
    end
  endgenerate

  localparam logic [0:0]    S_FILL    = 1'b0;
  localparam logic [0:0]    S_FULL    = 1'b1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS - 1);

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         pad_q, pad_d;
  logic [DATA_WIDTH-1:0] block_q, block_d;

  logic          accept;
  logic          closing;
  logic [CW-1:0] wr_idx;

  // Ready is forced low during reset; in FULL it follows the consumer so a new
  // word can open the next block in the same cycle the held one is taken.
  assign word_ready_o = rst_ni & ((state_q == S_FILL) | block_ready_i);
  assign accept       = word_valid_i & word_ready_o;
  assign wr_idx       = (state_q == S_FULL) ? '0 : count_q;
  assign closing      = accept & (last_i | (wr_idx == LAST_SLOT));

  assign block_o           = block_q;
  assign block_valid_o     = (state_q == S_FULL);
  assign block_pad_count_o = pad_q;

  generate
    for (genvar gi = 0; gi < int'(WORDS); gi++) begin : g_slot
      localparam logic [CW-1:0] SLOT = CW'(gi);
      always_comb begin
        block_d[gi*WORD_WIDTH +: WORD_WIDTH] = block_q[gi*WORD_WIDTH +: WORD_WIDTH];
        if (accept) begin
          if (wr_idx == SLOT) begin
            block_d[gi*WORD_WIDTH +: WORD_WIDTH] = word_i;
          end else if (last_i && (SLOT > wr_idx)) begin
            block_d[gi*WORD_WIDTH +: WORD_WIDTH] = PAD_WORD;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pad_d   = pad_q;
    if (state_q == S_FILL) begin
      if (closing) begin
        state_d = S_FULL;
        count_d = '0;
        pad_d   = LAST_SLOT - wr_idx;
      end else if (accept) begin
        count_d = count_q + CW'(1);
      end
    end else if (block_ready_i) begin
      if (closing) begin
        // Turnover straight into another complete block: no bubble on valid.
        count_d = '0;
        pad_d   = LAST_SLOT - wr_idx;
      end else if (accept) begin
        state_d = S_FILL;
        count_d = CW'(1);
      end else begin
        state_d = S_FILL;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FILL;
      count_q <= '0;
      pad_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pad_q   <= pad_d;
      block_q <= block_d;
    end
  end

endmodule

// File: tb/tb_tx3_block_assembler.sv
// Directed bench for tx3_block_assembler (64-bit blocks of 8-bit words, pad 8'h80).
// Inputs change and outputs are sampled 1ns after the rising clock edge.
module tb_tx3_block_assembler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        last_i;
  logic [63:0] block_o;
  logic        block_valid_o;
  logic        block_ready_i;
  logic [3:0]  block_pad_count_o;

  int n_cmp = 0;
  int n_err = 0;

  tx3_block_assembler #(
    .DATA_WIDTH(64),
    .WORD_WIDTH(8),
    .PAD_WORD(8'h80)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .word_i(word_i),
    .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o),
    .last_i(last_i),
    .block_o(block_o),
    .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i),
    .block_pad_count_o(block_pad_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni        = 1'b0;
    word_i        = 8'h00;
    word_valid_i  = 1'b0;
    last_i        = 1'b0;
    block_ready_i = 1'b0;
    #1;
    chk("rst_ready", {63'd0, word_ready_o}, 64'd0);
    chk("rst_valid", {63'd0, block_valid_o}, 64'd0);
    chk("rst_block", block_o, 64'd0);
    chk("rst_pad", {60'd0, block_pad_count_o}, 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("fill_ready", {63'd0, word_ready_o}, 64'd1);

    // 1: eight words 01..08 back to back, consumer stalled
    word_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word_i = 8'(i + 1);
      tick();
      if (i == 6) chk("t1_valid_early", {63'd0, block_valid_o}, 64'd0);
    end
    chk("t1_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t1_block", block_o, 64'h0807060504030201);
    chk("t1_pad", {60'd0, block_pad_count_o}, 64'd0);
    chk("t1_ready", {63'd0, word_ready_o}, 64'd0);

    // 3: hold for 10 cycles with a word pending; nothing may be accepted
    word_i = 8'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_block", block_o, 64'h0807060504030201);
      chk("t3_hold_ready", {63'd0, word_ready_o}, 64'd0);
    end
    word_valid_i  = 1'b0;
    block_ready_i = 1'b1;
    #1;
    chk("t3_ready_comb", {63'd0, word_ready_o}, 64'd1);
    tick();
    chk("t3_released", {63'd0, block_valid_o}, 64'd0);
    block_ready_i = 1'b0;

    // 2: AA BB CC with last on CC -> padded block
    word_valid_i = 1'b1;
    word_i = 8'hAA; tick();
    word_i = 8'hBB; tick();
    chk("t2_valid_early", {63'd0, block_valid_o}, 64'd0);
    word_i = 8'hCC; last_i = 1'b1; tick();
    word_valid_i = 1'b0; last_i = 1'b0;
    chk("t2_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t2_block", block_o, 64'h80808080_80CCBBAA);
    chk("t2_pad", {60'd0, block_pad_count_o}, 64'd5);

    // 4: consumer takes the block while 5A is offered; 5A opens the next block
    block_ready_i = 1'b1;
    word_valid_i  = 1'b1;
    word_i        = 8'h5A;
    #1;
    chk("t4_ready_comb", {63'd0, word_ready_o}, 64'd1);
    tick();
    chk("t4_turn_valid", {63'd0, block_valid_o}, 64'd0);
    block_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      word_i = 8'(8'h5B + i);
      tick();
      if (i == 5) chk("t4_valid_early", {63'd0, block_valid_o}, 64'd0);
    end
    word_valid_i = 1'b0;
    chk("t4_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t4_block", block_o, 64'h61605F5E5D5C5B5A);
    chk("t4_pad", {60'd0, block_pad_count_o}, 64'd0);
    block_ready_i = 1'b1;
    tick();
    chk("t4_released", {63'd0, block_valid_o}, 64'd0);
    block_ready_i = 1'b0;

    // 5: reset after four accepted words discards the partial block
    word_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word_i = 8'(8'h21 + i);
      tick();
    end
    word_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_block", block_o, 64'd0);
    chk("t5_rst_valid", {63'd0, block_valid_o}, 64'd0);
    chk("t5_rst_ready", {63'd0, word_ready_o}, 64'd0);
    chk("t5_rst_pad", {60'd0, block_pad_count_o}, 64'd0);
    #1;
    rst_ni = 1'b1;
    tick();
    word_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word_i = 8'(8'h31 + i);
      tick();
    end
    word_valid_i = 1'b0;
    chk("t5_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t5_block", block_o, 64'h3837363534333231);
    chk("t5_pad", {60'd0, block_pad_count_o}, 64'd0);
    block_ready_i = 1'b1;
    tick();
    chk("t5_released", {63'd0, block_valid_o}, 64'd0);
    block_ready_i = 1'b0;

    // 6: single-word block, then a last word during the handshake keeps valid high
    word_valid_i = 1'b1;
    word_i = 8'h11;
    last_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    chk("t6_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t6_block", block_o, 64'h80808080_80808011);
    chk("t6_pad", {60'd0, block_pad_count_o}, 64'd7);
    block_ready_i = 1'b1;
    word_valid_i  = 1'b1;
    word_i        = 8'h22;
    tick();
    word_valid_i = 1'b0;
    last_i = 1'b0;
    chk("t6_turn_valid", {63'd0, block_valid_o}, 64'd1);
    chk("t6_turn_block", block_o, 64'h80808080_80808022);
    chk("t6_turn_pad", {60'd0, block_pad_count_o}, 64'd7);
    tick();
    chk("t6_released", {63'd0, block_valid_o}, 64'd0);
    block_ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
